// File: rtl/sd_spi_xfer_ctrl.sv
// sd_spi_xfer_ctrl: SPI transfer controller for the MicroSD shift stage (sclk/cs_n, word load/capture, init dummy clocks).
// Optional build macro SPI_CS_HOLD_EN adds a cs_hold input that keeps cs_n asserted between transfers.
`default_nettype none

module sd_spi_xfer_ctrl #(
  parameter int N          = 16,
  parameter int DIV_FAST   = 2,
  parameter int DIV_SLOW   = 64,
  parameter int DUMMY_CLKS = 80
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         init,
  input  logic         start,
  input  logic         slow,
`ifdef SPI_CS_HOLD_EN
  input  logic         cs_hold,
`endif
  input  logic [N-1:0] tx_data,
  output logic [N-1:0] rx_data,
  output logic         busy,
  output logic         done,
  output logic         sclk,
  output logic         cs_n,
  output logic [N-1:0] data_se,
  input  logic [N-1:0] data_re
);

  localparam int DIV_MAX = (DIV_FAST > DIV_SLOW) ? DIV_FAST : DIV_SLOW;
  localparam int DW      = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
  localparam int BW      = $clog2(N + 1);
  localparam int CW      = $clog2(DUMMY_CLKS + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INIT    = 3'd1,
    S_SETUP   = 3'd2,
    S_XFER    = 3'd3,
    S_CAPTURE = 3'd4,
    S_FINISH  = 3'd5
  } state_t;

  state_t         state_q;
  logic [DW-1:0]  div_q;
  logic [BW-1:0]  bit_q;
  logic [CW-1:0]  dcnt_q;
  logic           slow_q;
  logic           xfer_q;
  logic           sclk_q;
  logic           cs_n_q;
  logic           busy_q;
  logic           done_q;
  logic [N-1:0]   rx_q;
  logic [N-1:0]   se_q;

  logic [DW-1:0]  div_lim;
  logic           div_tc;
  logic           hold_en;

`ifdef SPI_CS_HOLD_EN
  assign hold_en = cs_hold;
`else
  assign hold_en = 1'b0;
`endif

  assign div_lim = slow_q ? DW'(DIV_SLOW - 1) : DW'(DIV_FAST - 1);
  assign div_tc  = (div_q == div_lim);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      dcnt_q  <= '0;
      slow_q  <= 1'b0;
      xfer_q  <= 1'b0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rx_q    <= '0;
      se_q    <= '1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          div_q  <= '0;
          bit_q  <= '0;
          dcnt_q <= '0;
          if (!hold_en) cs_n_q <= 1'b1;
          // init has priority; a simultaneous start is dropped
          if (init) begin
            slow_q  <= slow;
            xfer_q  <= 1'b0;
            busy_q  <= 1'b1;
            cs_n_q  <= 1'b1;
            se_q    <= '1;
            state_q <= S_INIT;
          end else if (start) begin
            slow_q  <= slow;
            xfer_q  <= 1'b1;
            busy_q  <= 1'b1;
            cs_n_q  <= 1'b0;
            se_q    <= tx_data;
            // card already selected from a held transfer: no setup gap needed
            state_q <= cs_n_q ? S_SETUP : S_XFER;
          end
        end

        S_INIT: begin
          if (div_tc) begin
            div_q <= '0;
            if (sclk_q) begin
              sclk_q <= 1'b0;
              dcnt_q <= dcnt_q + 1'b1;
              if (dcnt_q == CW'(DUMMY_CLKS - 1)) begin
                done_q  <= 1'b1;
                state_q <= S_FINISH;
              end
            end else begin
              sclk_q <= 1'b1;
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end

        S_SETUP: begin
          if (div_tc) begin
            div_q   <= '0;
            state_q <= S_XFER;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end

        S_XFER: begin
          if (div_tc) begin
            div_q <= '0;
            if (sclk_q) begin
              sclk_q <= 1'b0;
              bit_q  <= bit_q + 1'b1;
              if (bit_q == BW'(N - 1)) state_q <= S_CAPTURE;
            end else begin
              sclk_q <= 1'b1;
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end

        S_CAPTURE: begin
          if (div_tc) begin
            div_q   <= '0;
            rx_q    <= data_re;
            done_q  <= 1'b1;
            state_q <= S_FINISH;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end

        S_FINISH: begin
          busy_q  <= 1'b0;
          bit_q   <= '0;
          se_q    <= '1;
          cs_n_q  <= !(xfer_q && hold_en);
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rx_data = rx_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign sclk    = sclk_q;
  assign cs_n    = cs_n_q;
  assign data_se = se_q;

endmodule

`default_nettype wire

// File: tb/tb_sd_spi_xfer_ctrl.sv
// Scoreboard bench for sd_spi_xfer_ctrl: expected rx words queued at stimulus, compared at done.
`default_nettype none

module tb_sd_spi_xfer_ctrl;
  localparam int N  = 16;
  localparam int DF = 2;
  localparam int DS = 64;
  localparam int DC = 80;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         init = 1'b0;
  logic         start = 1'b0;
  logic         slow = 1'b0;
  logic [N-1:0] tx_data = '0;
  logic [N-1:0] data_re = '0;
  logic [N-1:0] rx_data;
  logic         busy;
  logic         done;
  logic         sclk;
  logic         cs_n;
  logic [N-1:0] data_se;
`ifdef SPI_CS_HOLD_EN
  logic         cs_hold = 1'b0;
`endif

  int           n_cmp = 0;
  int           n_err = 0;
  logic [N-1:0] sb_q[$];
  logic [N-1:0] exp_rx = '0;

  always #5 clk = ~clk;

  sd_spi_xfer_ctrl #(.N(N), .DIV_FAST(DF), .DIV_SLOW(DS), .DUMMY_CLKS(DC)) dut (
    .clk     (clk),
    .reset   (reset),
    .init    (init),
    .start   (start),
    .slow    (slow),
`ifdef SPI_CS_HOLD_EN
    .cs_hold (cs_hold),
`endif
    .tx_data (tx_data),
    .rx_data (rx_data),
    .busy    (busy),
    .done    (done),
    .sclk    (sclk),
    .cs_n    (cs_n),
    .data_se (data_se),
    .data_re (data_re)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one request, observe it to done, then confirm the block settles quietly.
  task automatic run_op(input string tag, input bit do_init, input bit do_start, input bit slw,
                        input logic [N-1:0] tx, input logic [N-1:0] re, input int mid_start,
                        input int exp_lat, input int exp_pulses, input int div,
                        input logic exp_cs, input logic [N-1:0] exp_se, input logic exp_cs_after);
    int cyc, rises, run, bad_ph, bad_cs, bad_se, extra;
    bit got;
    logic prev;
    logic [N-1:0] exp_word;
    @(negedge clk);
    tx_data = tx;
    data_re = re;
    slow    = slw;
    init    = do_init;
    start   = do_start;
    if (do_init) sb_q.push_back(exp_rx);
    else begin
      sb_q.push_back(re);
      exp_rx = re;
    end
    cyc = 1; rises = 0; run = 0; bad_ph = 0; bad_cs = 0; bad_se = 0; got = 0;
    prev = sclk;
    while (!got && cyc < 20000) begin
      @(negedge clk);
      init  = 1'b0;
      start = (cyc == mid_start);
      cyc++;
      if (sclk && !prev) rises++;
      if (sclk != prev) begin
        if (prev && run != div) bad_ph++;
        run = 1;
      end else begin
        run++;
      end
      prev = sclk;
      if (busy) begin
        if (cs_n !== exp_cs) bad_cs++;
        if (data_se !== exp_se) bad_se++;
      end
      if (done) got = 1;
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, cyc, exp_lat);
    check({tag, "_pulses"}, rises, exp_pulses);
    check({tag, "_high_phase_bad"}, bad_ph, 0);
    check({tag, "_cs_bad"}, bad_cs, 0);
    check({tag, "_data_se_bad"}, bad_se, 0);
    exp_word = sb_q.pop_front();
    check({tag, "_rx_data"}, 32'(rx_data), 32'(exp_word));
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) extra++;
    end
    check({tag, "_extra_done"}, extra, 0);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_cs_after"}, 32'(cs_n), 32'(exp_cs_after));
  endtask

  initial begin
    int cyc, falls, dn;
    logic prev;

    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rx", 32'(rx_data), 32'h0000);
    check("rst_data_se", 32'(data_se), 32'hFFFF);

    run_op("init_slow", 1, 0, 1, 16'h1234, 16'hBEEF, -1, 2 + 2*DC*DS, DC, DS, 1'b1, 16'hFFFF, 1'b1);
    run_op("xfer_fast", 0, 1, 0, 16'hA55A, 16'h3C96, -1, 70, N, DF, 1'b0, 16'hA55A, 1'b1);
    run_op("init_start", 1, 1, 0, 16'h0F0F, 16'h1111, -1, 2 + 2*DC*DF, DC, DF, 1'b1, 16'hFFFF, 1'b1);
    run_op("mid_start", 0, 1, 0, 16'h5AA5, 16'hC3E1, 20, 70, N, DF, 1'b0, 16'h5AA5, 1'b1);

    // Abort a transfer partway through with reset, once sclk is high after the 5th fall.
    @(negedge clk);
    tx_data = 16'h6C39;
    data_re = 16'h9999;
    slow    = 1'b0;
    start   = 1'b1;
    cyc = 0; falls = 0;
    prev = sclk;
    while (!(falls >= 5 && sclk) && cyc < 1000) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (!sclk && prev) falls++;
      prev = sclk;
    end
    check("abort_reached", 32'(falls), 32'd5);
    #1 reset = 1'b0;
    #1;
    check("abort_sclk", 32'(sclk), 32'd0);
    check("abort_cs_n", 32'(cs_n), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rx", 32'(rx_data), 32'h0000);
    exp_rx = '0;
    dn = 0;
    repeat (5) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("abort_no_done", dn, 0);
    reset = 1'b1;
    run_op("post_abort", 0, 1, 0, 16'h6C39, 16'h7E18, -1, 70, N, DF, 1'b0, 16'h6C39, 1'b1);

`ifdef SPI_CS_HOLD_EN
    cs_hold = 1'b1;
    run_op("hold_first", 0, 1, 0, 16'h1357, 16'h2468, -1, 70, N, DF, 1'b0, 16'h1357, 1'b0);
    run_op("hold_second", 0, 1, 0, 16'h9BDF, 16'hACE0, -1, 70 - DF, N, DF, 1'b0, 16'h9BDF, 1'b0);
    @(negedge clk);
    cs_hold = 1'b0;
    @(negedge clk);
    check("hold_release", 32'(cs_n), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
